rv_fetch: RTL

Instruction fetch stage for the single-issue RV32 core. Holds the program counter, issues word fetches to instruction memory over a single-outstanding request/response interface, and presents fetched instructions in a one-entry IF/ID register. `opcode_o` drives the control decoder's `opcode_i` directly. Branch redirects from execute flush the stage and discard any in-flight response.

---
 rtl/rv_fetch.sv | 90 +++++++++
 1 files changed

// File: rtl/rv_fetch.sv
// RV32 instruction fetch: PC, single-outstanding imem request/response, one-entry IF/ID register.
// Response-to-valid latency 1 cycle; stall holds the slot, redirect flushes it and kills any in-flight response.
module rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [6:0]  opcode_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        slot_free;
    logic [31:0] redirect_target;

    assign slot_free       = ~instr_valid_o | ~stall_i;
    assign redirect_target = {redirect_pc_i[31:2], 2'b00};

    // Reset gating keeps the strobe low while rst_i is held, even though IDLE with an empty slot would request.
    assign imem_req_o  = ~rst_i & (state == IDLE) & ~redirect_i & slot_free;
    assign imem_addr_o = pc;
    assign opcode_o    = instr_o[6:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            req_pc        <= 32'h0000_0000;
            instr_valid_o <= 1'b0;
            instr_o       <= 32'h0000_0013;
            instr_pc_o    <= 32'h0000_0000;
        end else begin
            if (instr_valid_o && !stall_i) begin
                instr_valid_o <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        pc            <= redirect_target;
                        instr_valid_o <= 1'b0;
                    end else if (slot_free) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_i) begin
                        pc            <= redirect_target;
                        instr_valid_o <= 1'b0;
                        state         <= imem_rvalid_i ? IDLE : KILL;
                    end else if (imem_rvalid_i) begin
                        instr_valid_o <= 1'b1;
                        instr_o       <= imem_rdata_i;
                        instr_pc_o    <= req_pc;
                        state         <= IDLE;
                    end
                end
                KILL: begin
                    if (redirect_i) begin
                        pc            <= redirect_target;
                        instr_valid_o <= 1'b0;
                    end
                    if (imem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
